// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_pkg
// Purpose  : Shared types and sizing helpers for the serial adder controller
// Revision : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

  // Default operand width used by every block in this slice
  localparam int SAC_WIDTH_DEFAULT = 8;

  // Controller state encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sac_state_t;

  // Bit counter width: must hold the index of the final (carry) capture
  function automatic int sac_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage : serial_add_pkg
`default_nettype wire

// File: rtl/serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl_if
// Purpose  : Operand-in / sum-out valid-ready bus of the serial adder controller
// Revision : 1.0 - initial release
// ============================================================================
interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SAC_WIDTH_DEFAULT
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;

  // Producer/consumer side (upstream stage plus downstream sink)
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum
  );

  // Controller side
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum
  );

endinterface : serial_add_ctrl_if
`default_nettype wire

// File: rtl/piso_shreg.sv
`default_nettype none
// ============================================================================
// Module   : piso_shreg
// Purpose  : Parallel-load, shift-right, zero-fill register; LSB is the
//            serial output
// Revision : 1.0 - initial release
// ============================================================================
module piso_shreg
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SAC_WIDTH_DEFAULT
) (
  input  wire logic             clk_i,
  input  wire logic             rst_ni,
  input  wire logic             load_i,
  input  wire logic             shift_i,
  input  wire logic [WIDTH-1:0] data_i,
  output logic                  lsb_o
);

  logic [WIDTH-1:0] data_q;

  // Load has priority; shifting feeds zeros in from the top so the register
  // naturally drains to zero once all bits have been sent
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= data_i;
    end else if (shift_i) begin
      data_q <= {1'b0, data_q[WIDTH-1:1]};
    end
  end

  assign lsb_o = data_q[0];

endmodule : piso_shreg
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Purpose  : Feeds two parallel operands LSB-first into an external bit-serial
//            adder and reassembles its serial sum into a WIDTH+1-bit result
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SAC_WIDTH_DEFAULT
) (
  input  wire logic         clk,
  input  wire logic         reset,     // asynchronous, active-low
  serial_add_ctrl_if.slave  bus,
  output logic              x,
  output logic              y,
  output logic              add_clr,
  input  wire logic         s
);

  localparam int CNT_W = sac_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH);

  sac_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   result_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             add_clr_q;

  logic             load;
  logic             shift;

  // An operand pair is taken only in IDLE; in_valid elsewhere is dropped
  assign load  = (state_q == IDLE) && bus.in_valid && in_ready_q;
  assign shift = (state_q == SHIFT);

  // Operand shift registers; their LSBs drive the adder directly, and they
  // are already zero outside SHIFT, so x/y idle low without extra gating
  piso_shreg #(.WIDTH(WIDTH)) u_sr_a (
    .clk_i   (clk),
    .rst_ni  (reset),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (bus.a),
    .lsb_o   (x)
  );

  piso_shreg #(.WIDTH(WIDTH)) u_sr_b (
    .clk_i   (clk),
    .rst_ni  (reset),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (bus.b),
    .lsb_o   (y)
  );

  // Control FSM with registered handshake outputs and inline result collector
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      add_clr_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          // add_clr is still high on this edge, so the adder carry starts at 0
          if (load) begin
            cnt_q      <= '0;
            result_q   <= '0;
            in_ready_q <= 1'b0;
            add_clr_q  <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          // Sum bits arrive LSB first; shift them in from the top
          result_q <= {s, result_q[WIDTH:1]};
          if (cnt_q == LAST_BIT) begin
            // This capture was taken with x=y=0, i.e. it is the final carry
            out_valid_q <= 1'b1;
            add_clr_q   <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          add_clr_q   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = result_q;
  assign add_clr       = add_clr_q;

endmodule : serial_add_ctrl
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_ctrl
// Purpose  : Self-checking bench for serial_add_ctrl with a behavioural
//            bit-serial adder attached
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

  localparam int W       = 8;
  localparam int TIMEOUT = 60;

  logic clk = 1'b0;
  logic reset;
  logic x, y, add_clr, s;
  logic carry_q = 1'b0;

  int checks   = 0;
  int failures = 0;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .x       (x),
    .y       (y),
    .add_clr (add_clr),
    .s       (s)
  );

  always #5 clk = ~clk;

  // Bit-serial adder: full adder plus carry DFF with synchronous clear
  assign s = x ^ y ^ carry_q;
  always @(posedge clk) begin
    if (add_clr) carry_q <= 1'b0;
    else         carry_q <= (x & y) | (x & carry_q) | (y & carry_q);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction; called and returns on a falling edge with the DUT idle
  task automatic run_op(input logic [W-1:0] opa, input logic [W-1:0] opb, input int hold);
    logic [W:0] exp_sum;
    int n;
    int idx;
    exp_sum = {1'b0, opa} + {1'b0, opb};
    check("idle_in_ready", bus.in_ready, 1);
    check("idle_add_clr", add_clr, 1);
    bus.in_valid  = 1'b1;
    bus.a         = opa;
    bus.b         = opb;
    bus.out_ready = (hold == 0);
    @(negedge clk);
    // Operands may change freely once accepted
    bus.in_valid = 1'b0;
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    n = 1;
    while (!bus.out_valid && n < TIMEOUT) begin
      idx = n - 1;
      check("shift_x", x, (idx < W) ? opa[idx] : 1'b0);
      check("shift_y", y, (idx < W) ? opb[idx] : 1'b0);
      check("shift_in_ready", bus.in_ready, 0);
      check("shift_add_clr", add_clr, 0);
      @(negedge clk);
      n++;
    end
    check("latency", n - 1, W + 1);
    check("sum", bus.sum, exp_sum);
    check("done_add_clr", add_clr, 1);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_sum", bus.sum, exp_sum);
      check("hold_in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("release_sum", bus.sum, exp_sum);
    @(negedge clk);
    check("back_idle_out_valid", bus.out_valid, 0);
    check("back_idle_in_ready", bus.in_ready, 1);
    check("back_idle_x", x, 0);
  endtask

  initial begin
    int n;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    // Reset values must not depend on the input side
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'($urandom);
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      @(negedge clk);
      check("rst_sum", bus.sum, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_add_clr", add_clr, 1);
      check("rst_x", x, 0);
    end
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(8'd3, 8'd5, 0);
    run_op(8'hFF, 8'h01, 0);
    run_op(8'hFF, 8'hFF, 0);
    run_op(8'h00, 8'h00, 0);
    run_op(8'h5A, 8'h0F, 5);

    // Reset in the middle of SHIFT, after four serial edges
    bus.in_valid = 1'b1;
    bus.a        = 8'hFF;
    bus.b        = 8'hFF;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    check("pre_rst_in_ready", bus.in_ready, 0);
    reset = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_x", x, 0);
    check("midrst_y", y, 0);
    check("midrst_add_clr", add_clr, 1);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_sum", bus.sum, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_op(8'd1, 8'd1, 0);

    // Randomized operands and backpressure
    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)));
    end

    // Idle gap with no request must stay idle
    n = 0;
    repeat (3) begin
      @(negedge clk);
      n++;
    end
    check("idle_hold_in_ready", bus.in_ready, 1);
    check("idle_hold_out_valid", bus.out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_add_ctrl
`default_nettype wire
